msk_rnd_prng: RTL and testbench

- Fresh-randomness source for masked gadgets.
- Drives the random bus of a bank of HPC3-style masked AND gadgets: W bits per cycle, consumed at latency 0.
- Built from W independent PRBS31 lanes. The lanes are seeded over a narrow handshake interface and warmed up before output is declared valid.
- Sits directly upstream of the gadget rnd inputs.

---
 rtl/msk_rnd_prng.sv | 133 +++++++++++++
 tb/tb_msk_rnd_prng.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/msk_rnd_prng.sv
// Fresh-randomness source for a bank of masked AND gadgets.
// W parallel PRBS31 lanes, seeded over a word-serial handshake and warmed up before use.
module msk_rnd_prng #(
  parameter int unsigned D      = 2,
  parameter int unsigned W      = D * (D - 1),
  parameter int unsigned WARMUP = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_start,
  input  logic [30:0]  seed_in,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic         rnd_ready,
  output logic         rnd_valid,
  output logic [W-1:0] rnd,
  output logic         busy,
  output logic         zero_seed_err
);

  localparam int unsigned LW  = 31;
  localparam int unsigned CW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEED     = 2'd1,
    WARM     = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   lane_cnt, lane_cnt_nxt;
  logic [WCW-1:0]  warm_cnt, warm_cnt_nxt;
  logic [LW-1:0]   lanes     [W];
  logic [LW-1:0]   lanes_nxt [W];
  logic            err_nxt;
  logic            adv;
  logic            load;
  logic [LW-1:0]   seed_word;

  // Next-state, lane update and sticky error computation.
  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    warm_cnt_nxt = warm_cnt;
    lanes_nxt    = lanes;
    err_nxt      = zero_seed_err;
    adv          = 1'b0;
    load         = 1'b0;
    seed_word    = (seed_in == '0) ? LW'(1) : seed_in;

    unique case (state)
      UNSEEDED: begin
      end
      SEED: begin
        if (seed_valid && seed_ready && !seed_start) begin
          load         = 1'b1;
          lane_cnt_nxt = CW'(lane_cnt + 1'b1);
          if (lane_cnt == CW'(W - 1)) begin
            lane_cnt_nxt = '0;
            warm_cnt_nxt = '0;
            state_nxt    = (WARMUP > 0) ? WARM : RUN;
          end
        end
      end
      WARM: begin
        adv          = 1'b1;
        warm_cnt_nxt = WCW'(warm_cnt + 1'b1);
        if (warm_cnt == WCW'(WARMUP - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        adv = rnd_valid && rnd_ready;
      end
      default: begin
      end
    endcase

    // Reseed request wins over any word offered in the same cycle.
    if (seed_start) begin
      state_nxt    = SEED;
      lane_cnt_nxt = '0;
    end

    if (adv) begin
      for (int k = 0; k < int'(W); k++) begin
        lanes_nxt[k] = {lanes[k][29:0], lanes[k][30] ^ lanes[k][27]};
      end
    end

    if (load) begin
      lanes_nxt[lane_cnt] = seed_word;
      if (seed_in == '0) begin
        err_nxt = 1'b1;
      end
    end
  end

  // State, counters, lanes and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= UNSEEDED;
      lane_cnt      <= '0;
      warm_cnt      <= '0;
      zero_seed_err <= 1'b0;
      seed_ready    <= 1'b0;
      rnd_valid     <= 1'b0;
      busy          <= 1'b0;
      for (int k = 0; k < int'(W); k++) begin
        lanes[k] <= LW'(1);
      end
    end else begin
      state         <= state_nxt;
      lane_cnt      <= lane_cnt_nxt;
      warm_cnt      <= warm_cnt_nxt;
      zero_seed_err <= err_nxt;
      seed_ready    <= (state_nxt == SEED);
      rnd_valid     <= (state_nxt == RUN);
      busy          <= (state_nxt == SEED) || (state_nxt == WARM);
      for (int k = 0; k < int'(W); k++) begin
        lanes[k] <= lanes_nxt[k];
      end
    end
  end

  // Output bit k is the MSB of lane k, taken directly from the lane register.
  for (genvar g = 0; g < int'(W); g++) begin : g_rnd
    assign rnd[g] = lanes[g][30];
  end

endmodule

// File: tb/tb_msk_rnd_prng.sv
// Self-checking bench for msk_rnd_prng: two instances (WARMUP = 0 and 30), W = 2,
// compared against a transaction-level PRBS31 lane model.
module tb_msk_rnd_prng;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ss = '0;
  logic [1:0]  sv = '0;
  logic [1:0]  rr = '0;
  logic [30:0] si_a = '0;
  logic [30:0] si_b = '0;
  logic        sr_a, rv_a, bz_a, ze_a;
  logic        sr_b, rv_b, bz_b, ze_b;
  logic [1:0]  rn_a, rn_b;

  int checks = 0;
  int errors = 0;

  // Model: lane contents per instance and sticky zero-seed flag.
  logic [30:0] m [2][2];
  logic        merr [2];

  always #5 clk = ~clk;

  msk_rnd_prng #(.D(2), .WARMUP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_start(ss[0]), .seed_in(si_a), .seed_valid(sv[0]),
    .seed_ready(sr_a), .rnd_ready(rr[0]), .rnd_valid(rv_a), .rnd(rn_a), .busy(bz_a),
    .zero_seed_err(ze_a)
  );

  msk_rnd_prng #(.D(2), .WARMUP(30)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_start(ss[1]), .seed_in(si_b), .seed_valid(sv[1]),
    .seed_ready(sr_b), .rnd_ready(rr[1]), .rnd_valid(rv_b), .rnd(rn_b), .busy(bz_b),
    .zero_seed_err(ze_b)
  );

  function automatic logic [30:0] prbs_next(input logic [30:0] s);
    longint unsigned v;
    longint unsigned fb;
    v  = longint'(s);
    fb = ((v / 64'h4000_0000) ^ (v / 64'h0800_0000)) % 2;
    return 31'((v * 2 + fb) % 64'h8000_0000);
  endfunction

  function automatic logic [1:0] exp_rnd(input int u);
    return {m[u][1][30], m[u][0][30]};
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int u);
    for (int j = 0; j < 2; j++) m[u][j] = prbs_next(m[u][j]);
  endtask

  task automatic chk(input int u, input string tag, input logic v, input logic r, input logic b);
    cmp({tag, ".rnd_valid"},  32'(u != 0 ? rv_b : rv_a), 32'(v));
    cmp({tag, ".seed_ready"}, 32'(u != 0 ? sr_b : sr_a), 32'(r));
    cmp({tag, ".busy"},       32'(u != 0 ? bz_b : bz_a), 32'(b));
    cmp({tag, ".zero_err"},   32'(u != 0 ? ze_b : ze_a), 32'(merr[u]));
    cmp({tag, ".rnd"},        32'(u != 0 ? rn_b : rn_a), 32'(exp_rnd(u)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ss = '0; sv = '0; rr = '0;
    #2;
    for (int u = 0; u < 2; u++) begin
      m[u][0] = 31'h1; m[u][1] = 31'h1; merr[u] = 1'b0;
      chk(u, "reset_async", 1'b0, 1'b0, 1'b0);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_seed(input int u, input logic [30:0] s);
    if (u != 0) si_b = s; else si_a = s;
  endtask

  // Pulse seed_start, deliver both words, run out warm-up; ends in RUN.
  task automatic reseed(input int u, input logic [30:0] s0, input logic [30:0] s1, input int warm);
    logic [30:0] s [2];
    s[0] = s0; s[1] = s1;
    ss[u] = 1'b1;
    step();
    ss[u] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk(u, "seed", 1'b0, 1'b1, 1'b1);
      sv[u] = 1'b1;
      set_seed(u, s[j]);
      step();
      m[u][j] = (s[j] == 0) ? 31'h1 : s[j];
      if (s[j] == 0) merr[u] = 1'b1;
    end
    sv[u] = 1'b0;
    for (int i = 0; i < warm; i++) begin
      chk(u, "warm", 1'b0, 1'b0, 1'b1);
      step();
      advance(u);
    end
    chk(u, "run_entry", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      chk(u, "run", 1'b1, 1'b0, 1'b0);
      rr[u] = 1'($urandom_range(0, 1));
      step();
      if (rr[u]) advance(u);
    end
    rr[u] = 1'b0;
  endtask

  initial begin
    logic [30:0] r0, r1;
    int          pat [4];

    do_reset();

    // Idle after reset: nothing happens without seed_start.
    for (int i = 0; i < 10; i++) begin
      chk(0, "idle_a", 1'b0, 1'b0, 1'b0);
      chk(1, "idle_b", 1'b0, 1'b0, 1'b0);
      step();
    end

    // WARMUP = 0, both seeds 1: 30 zero outputs then 2'b11.
    reseed(0, 31'h1, 31'h1, 0);
    for (int i = 1; i <= 31; i++) begin
      chk(0, "seq1", 1'b1, 1'b0, 1'b0);
      cmp("seq1_value", 32'(rn_a), (i == 31) ? 32'h3 : 32'h0);
      rr[0] = 1'b1;
      step();
      advance(0);
    end
    rr[0] = 1'b0;
    run(0, 150);

    // WARMUP = 30: first valid output has lane0 MSB set.
    reseed(1, 31'h1, 31'h4000_0000, 30);
    cmp("first_valid_lane0", 32'(rn_b[0]), 32'h1);
    run(1, 100);

    // Handshake pattern 1,0,0,1: advance only on the handshakes.
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      chk(1, "toggle", 1'b1, 1'b0, 1'b0);
      rr[1] = 1'(pat[i]);
      step();
      if (pat[i] != 0) advance(1);
    end
    rr[1] = 1'b0;

    // Zero seed on lane 1 sets the sticky flag; it survives a reseed.
    r0 = 31'($urandom) | 31'h1;
    reseed(1, r0, 31'h0, 30);
    cmp("zero_err_set", 32'(ze_b), 32'h1);
    run(1, 60);
    r0 = 31'($urandom) | 31'h2;
    r1 = 31'($urandom) | 31'h4;
    reseed(1, r0, r1, 30);
    cmp("zero_err_sticky", 32'(ze_b), 32'h1);
    run(1, 40);

    // seed_start mid-WARM with a same-cycle seed word that must be ignored.
    ss[1] = 1'b1;
    step();
    ss[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      sv[1] = 1'b1;
      r0 = 31'($urandom) | 31'h8;
      set_seed(1, r0);
      step();
      m[1][j] = r0;
    end
    sv[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk(1, "warm_pre", 1'b0, 1'b0, 1'b1);
      step();
      advance(1);
    end
    ss[1] = 1'b1; sv[1] = 1'b1; set_seed(1, 31'h7FFF_FFFF);
    step();
    advance(1);
    ss[1] = 1'b0; sv[1] = 1'b0;
    chk(1, "warm_abort", 1'b0, 1'b1, 1'b1);
    step();
    chk(1, "warm_abort_hold", 1'b0, 1'b1, 1'b1);
    r0 = 31'($urandom) | 31'h10;
    r1 = 31'($urandom) | 31'h20;
    reseed(1, r0, r1, 30);
    run(1, 60);

    // seed_start in RUN together with a handshake and a seed word.
    chk(1, "run_pre", 1'b1, 1'b0, 1'b0);
    ss[1] = 1'b1; sv[1] = 1'b1; rr[1] = 1'b1; set_seed(1, 31'h0);
    step();
    advance(1);
    ss[1] = 1'b0; sv[1] = 1'b0; rr[1] = 1'b0;
    chk(1, "run_abort", 1'b0, 1'b1, 1'b1);
    r0 = 31'($urandom) | 31'h40;
    r1 = 31'($urandom) | 31'h80;
    reseed(1, r0, r1, 30);
    run(1, 80);

    // Reset in RUN clears everything, including the sticky flag.
    r0 = 31'($urandom) | 31'h100;
    r1 = 31'($urandom) | 31'h200;
    reseed(0, r0, r1, 0);
    run(0, 20);
    do_reset();
    cmp("zero_err_cleared", 32'(ze_b), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk(0, "post_reset_a", 1'b0, 1'b0, 1'b0);
      chk(1, "post_reset_b", 1'b0, 1'b0, 1'b0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
